// File: rtl/puzzle_pkg.sv
// puzzle_pkg: shared encodings, solved layout and move/BCD helpers for the 3x3 sliding puzzle
package puzzle_pkg;
    typedef enum logic [1:0] {IDLE, MOVE, CHECK, SHUFFLE} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    localparam logic [35:0] SOLVED_GRID = 36'h123456780;
    localparam int CELL_ROW [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    localparam int CELL_NIB [9] = '{2, 1, 0, 2, 1, 0, 2, 1, 0};
    function automatic logic move_legal(input dir_t d, input logic [3:0] p);
        return d == DIR_UP ? p >= 4'd3 : d == DIR_DOWN ? p <= 4'd5 :
               d == DIR_LEFT ? p % 4'd3 != 4'd0 : p % 4'd3 != 4'd2;
    endfunction
    function automatic logic [3:0] move_target(input dir_t d, input logic [3:0] p);
        return d == DIR_UP ? p - 4'd3 : d == DIR_DOWN ? p + 4'd3 :
               d == DIR_LEFT ? p - 4'd1 : p + 4'd1;
    endfunction
    // Saturating 4-digit BCD increment
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic c;
        r = v;
        c = v != 16'h9999;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
                else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/puzzle_btn_edge.sv
// puzzle_btn_edge: 2-flop synchronizer plus rising-edge detector, one pulse per press
module puzzle_btn_edge (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic pulse
);
    logic [2:0] sync;
    always_ff @(posedge clk or posedge clr) begin
        if (clr) sync <= '0;
        else sync <= {sync[1:0], btn};
    end
    assign pulse = sync[1] & ~sync[2];
endmodule

// File: rtl/puzzle_move_ctrl.sv
// puzzle_move_ctrl: 3x3 sliding puzzle controller with player moves, BCD move count and LFSR shuffle
module puzzle_move_ctrl
    import puzzle_pkg::*;
#(
    parameter int unsigned SHUFFLE_MOVES = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_load,
    output logic [11:0] row1,
    output logic [11:0] row2,
    output logic [11:0] row3,
    output logic [3:0]  blank_pos,
    output logic [15:0] move_count,
    output logic        solved,
    output logic        busy
);
    logic [4:0] btns, pulses;
    logic [3:0] cells [9];
    logic [11:0] rows [3];
    logic [15:0] lfsr;
    logic [7:0] scount;
    logic moved, ok, is_solved;
    logic [3:0] tgt;
    state_t state;
    dir_t dir, pick, mdir;
    assign btns = {btn_load, btn_up, btn_down, btn_left, btn_right};
    for (genvar i = 0; i < 5; i++) begin : g_btn
        puzzle_btn_edge u_edge (.clk(clk), .clr(clr), .btn(btns[i]), .pulse(pulses[i]));
    end
    always_comb begin
        rows = '{default: '0};
        for (int i = 0; i < 9; i++) rows[CELL_ROW[i]][CELL_NIB[i]*4 +: 4] = cells[i];
    end
    assign row1 = rows[0];
    assign row2 = rows[1];
    assign row3 = rows[2];
    assign is_solved = {row1, row2, row3} == SOLVED_GRID;
    assign pick = pulses[3] ? DIR_UP : pulses[2] ? DIR_DOWN : pulses[1] ? DIR_LEFT : DIR_RIGHT;
    assign mdir = state == SHUFFLE ? dir_t'(lfsr[1:0]) : dir;
    assign ok = move_legal(mdir, blank_pos);
    assign tgt = move_target(mdir, blank_pos);
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            dir <= DIR_UP;
            moved <= 1'b0;
            solved <= 1'b1;
            busy <= 1'b0;
            move_count <= '0;
            lfsr <= LFSR_SEED;
            scount <= '0;
            blank_pos <= 4'd8;
            for (int i = 0; i < 9; i++) cells[i] <= SOLVED_GRID[35-4*i -: 4];
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if ((state == MOVE || state == SHUFFLE) && ok) begin
                cells[blank_pos] <= cells[tgt];
                cells[tgt] <= 4'd0;
                blank_pos <= tgt;
            end
            case (state)
                IDLE: begin
                    if (pulses[4]) begin
                        state <= SHUFFLE;
                        busy <= 1'b1;
                        scount <= '0;
                    end else if (|pulses[3:0]) begin
                        state <= MOVE;
                        dir <= pick;
                    end
                end
                MOVE: begin
                    state <= CHECK;
                    moved <= ok;
                end
                CHECK: begin
                    state <= IDLE;
                    solved <= is_solved;
                    if (moved) move_count <= bcd_inc(move_count);
                end
                SHUFFLE: begin
                    // Illegal LFSR directions are skipped without consuming a shuffle step
                    if (ok) begin
                        scount <= scount + 8'd1;
                        if (scount == 8'(SHUFFLE_MOVES - 1)) begin
                            state <= CHECK;
                            busy <= 1'b0;
                            move_count <= '0;
                            moved <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_puzzle_move_ctrl.sv
// tb_puzzle_move_ctrl: random and directed stimulus against a cycle-stamped behavioural puzzle model
module tb_puzzle_move_ctrl;
    localparam int SM = 64;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int M_IDLE = 0, M_MOVE = 1, M_CHECK = 2, M_SHUF = 3;
    logic clk = 1'b0, clr = 1'b1;
    logic [4:0] bv = '0;
    logic [11:0] row1, row2, row3;
    logic [3:0] blank_pos;
    logic [15:0] move_count;
    logic solved, busy;
    int n_vec = 0, n_bad = 0;
    int mg [9];
    int mb, mode, mdir, sdone, cyc;
    int due [5];
    logic [4:0] last;
    logic [15:0] m_count, m_lfsr;
    logic m_solved, last_ok, model_ready = 1'b0;
    logic [15:0] force_val = '0;
    int force_seq = 0, force_done = 0;

    puzzle_move_ctrl #(.SHUFFLE_MOVES(SM), .LFSR_SEED(SEED)) dut (
        .clk(clk), .clr(clr),
        .btn_up(bv[3]), .btn_down(bv[2]), .btn_left(bv[1]), .btn_right(bv[0]), .btn_load(bv[4]),
        .row1(row1), .row2(row2), .row3(row3), .blank_pos(blank_pos),
        .move_count(move_count), .solved(solved), .busy(busy)
    );

    always #5 clk = ~clk;

    // Directions: 0 up, 1 down, 2 left, 3 right, reasoned in row/column coordinates
    function automatic bit m_legal(int d, int p);
        int r, c;
        r = p / 3;
        c = p % 3;
        return d == 0 ? r > 0 : d == 1 ? r < 2 : d == 2 ? c > 0 : c < 2;
    endfunction
    function automatic int m_target(int d, int p);
        int r, c;
        r = p / 3 + (d == 1 ? 1 : d == 0 ? -1 : 0);
        c = p % 3 + (d == 3 ? 1 : d == 2 ? -1 : 0);
        return 3 * r + c;
    endfunction
    function automatic logic [15:0] m_bcd_inc(logic [15:0] v);
        int n;
        n = 1000 * int'(v[15:12]) + 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
        if (n < 9999) n++;
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction
    function automatic logic [15:0] m_lfsr_next(logic [15:0] l);
        return {l[14:0], ^(l & 16'hB400)};
    endfunction
    function automatic logic grid_solved();
        for (int i = 0; i < 9; i++) if (mg[i] != (i < 8 ? i + 1 : 0)) return 1'b0;
        return 1'b1;
    endfunction
    function automatic logic [11:0] m_row(int r);
        return {4'(mg[3*r]), 4'(mg[3*r+1]), 4'(mg[3*r+2])};
    endfunction

    task automatic m_move(int d);
        int t;
        t = m_target(d, mb);
        mg[mb] = mg[t];
        mg[t] = 0;
        mb = t;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) mg[i] = i < 8 ? i + 1 : 0;
        for (int b = 0; b < 5; b++) due[b] = -10;
        mb = 8;
        m_count = '0;
        m_solved = 1'b1;
        mode = M_IDLE;
        m_lfsr = SEED;
        cyc = 0;
        last = '0;
        last_ok = 1'b0;
        sdone = 0;
        model_ready = 1'b1;
    endtask

    // A press first sampled high at edge k is acted on at edge k+2 if the controller is idle then
    task automatic model_step();
        logic [15:0] cur;
        logic [4:0] pl;
        cur = m_lfsr;
        m_lfsr = m_lfsr_next(m_lfsr);
        for (int b = 0; b < 5; b++) begin
            pl[b] = due[b] == cyc;
            if (bv[b] && !last[b]) due[b] = cyc + 2;
            last[b] = bv[b];
        end
        cyc++;
        if (mode == M_IDLE && force_done != force_seq) begin
            force dut.move_count = force_val;
            release dut.move_count;
            m_count = force_val;
            force_done = force_seq;
        end
        case (mode)
            M_SHUF: begin
                if (m_legal(int'(cur[1:0]), mb)) begin
                    m_move(int'(cur[1:0]));
                    sdone++;
                    if (sdone == SM) begin
                        mode = M_CHECK;
                        m_count = '0;
                        last_ok = 1'b0;
                    end
                end
            end
            M_MOVE: begin
                last_ok = m_legal(mdir, mb);
                if (last_ok) m_move(mdir);
                mode = M_CHECK;
            end
            M_CHECK: begin
                if (last_ok) m_count = m_bcd_inc(m_count);
                m_solved = grid_solved();
                mode = M_IDLE;
            end
            default: begin
                if (pl[4]) begin
                    mode = M_SHUF;
                    sdone = 0;
                end else begin
                    for (int b = 3; b >= 0; b--) begin
                        if (pl[b] && mode == M_IDLE) begin
                            mdir = 3 - b;
                            mode = M_MOVE;
                        end
                    end
                end
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk or posedge clr);
        if (clr) model_reset();
        else model_step();
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        check("row1", {4'h0, row1}, {4'h0, m_row(0)});
        check("row2", {4'h0, row2}, {4'h0, m_row(1)});
        check("row3", {4'h0, row3}, {4'h0, m_row(2)});
        check("blank_pos", {12'h0, blank_pos}, 16'(mb));
        check("move_count", move_count, m_count);
        check("solved", {15'h0, solved}, {15'h0, m_solved});
        check("busy", {15'h0, busy}, {15'h0, mode == M_SHUF});
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            if (!clr && model_ready) cmp_cycle();
        end
    endtask

    task automatic do_reset();
        bv = '0;
        clr = 1'b1;
        step(2);
        clr = 1'b0;
        step(2);
    endtask

    task automatic press(logic [4:0] mask, int hold);
        bv = mask;
        step(hold);
        bv = '0;
    endtask

    task automatic wait_idle(string nm);
        int t;
        t = 0;
        step(3);
        while (mode != M_IDLE && t < 3000) begin
            step(1);
            t++;
        end
        if (mode != M_IDLE) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", nm, t);
        end
        step(1);
    endtask

    task automatic check_reset_outputs(string nm);
        check({nm, "_row1"}, {4'h0, row1}, 16'h0123);
        check({nm, "_row2"}, {4'h0, row2}, 16'h0456);
        check({nm, "_row3"}, {4'h0, row3}, 16'h0780);
        check({nm, "_blank"}, {12'h0, blank_pos}, 16'h0008);
        check({nm, "_count"}, move_count, 16'h0000);
        check({nm, "_solved"}, {15'h0, solved}, 16'h0001);
        check({nm, "_busy"}, {15'h0, busy}, 16'h0000);
    endtask

    task automatic check_perm();
        logic [35:0] g;
        logic [15:0] seen;
        logic [3:0] v;
        int zpos;
        g = {row1, row2, row3};
        seen = '0;
        zpos = 15;
        for (int i = 0; i < 9; i++) begin
            v = g[35-4*i -: 4];
            seen[v] = 1'b1;
            if (v == 4'd0) zpos = i;
        end
        check("perm_cells", seen, 16'h01FF);
        check("perm_blank", 16'(zpos), {12'h0, blank_pos});
    endtask

    initial begin
        logic [4:0] mask;
        int r;
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [4:0] mask;
        int r;
        step(1);
        #1 check_reset_outputs("reset");
        do_reset();
        bv[1] = 1'b1;
        step(3);
        check("lat_grid_n2", {4'h0, row3}, 16'h0780);
        bv[1] = 1'b0;
        step(1);
        check("left_row3", {4'h0, row3}, 16'h0708);
        check("left_blank", {12'h0, blank_pos}, 16'h0007);
        check("lat_count_n3", move_count, 16'h0000);
        step(1);
        check("left_count", move_count, 16'h0001);
        check("left_solved", {15'h0, solved}, 16'h0000);
        wait_idle("left");
        do_reset();
        press(5'b00001, 2);
        wait_idle("illegal_right");
        press(5'b00100, 2);
        wait_idle("illegal_down");
        check("illegal_row3", {4'h0, row3}, 16'h0780);
        check("illegal_count", move_count, 16'h0000);
        check("illegal_solved", {15'h0, solved}, 16'h0001);
        do_reset();
        press(5'b00010, 1);
        wait_idle("lr_left");
        press(5'b00001, 1);
        wait_idle("lr_right");
        check("lr_grid", {4'h0, row1} ^ {4'h0, row2} ^ {4'h0, row3}, 16'h0123 ^ 16'h0456 ^ 16'h0780);
        check("lr_row3", {4'h0, row3}, 16'h0780);
        check("lr_count", move_count, 16'h0002);
        check("lr_solved", {15'h0, solved}, 16'h0001);
        do_reset();
        force_val = 16'h0999;
        force_seq++;
        step(2);
        press(5'b00010, 1);
        wait_idle("bcd_carry");
        check("bcd_carry", move_count, 16'h1000);
        force_val = 16'h9999;
        force_seq++;
        step(2);
        press(5'b00001, 1);
        wait_idle("bcd_sat");
        check("bcd_sat", move_count, 16'h9999);
        press(5'b10000, 1);
        step(4);
        check("shuf_busy", {15'h0, busy}, 16'h0001);
        press(5'b01000, 2);
        wait_idle("shuffle");
        check("shuf_count", move_count, 16'h0000);
        check("shuf_idle", {15'h0, busy}, 16'h0000);
        check_perm();
        press(5'b10000, 1);
        step(8);
        check("clr_busy_before", {15'h0, busy}, 16'h0001);
        #2 clr = 1'b1;
        #1 check_reset_outputs("clr_mid");
        step(2);
        clr = 1'b0;
        step(2);
        for (int k = 0; k < 300; k++) begin
            r = int'($urandom_range(0, 19));
            mask = r == 0 ? 5'b10000 : r < 4 ? 5'($urandom_range(1, 15)) : 5'(1 << $urandom_range(0, 3));
            press(mask, int'($urandom_range(1, 3)));
            step(int'($urandom_range(0, 8)));
            if (k % 50 == 49) check_perm();
        end
        wait_idle("random");
        check_perm();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
